vegeta_array_ctrl: RTL and testbench

//  Sequencer for one VEGETA PE array: drives weight shifting (weight_transferring, i_wb

---
 rtl/vegeta_ctrl_pkg.sv | 17 +
 rtl/vegeta_ctrl_cnt.sv | 26 ++
 rtl/vegeta_array_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_vegeta_array_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vegeta_ctrl_pkg.sv
// Shared types and helpers for the VEGETA PE-array sequencer.
package vegeta_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStream,
        StDrain,
        StDone
    } state_e;

    // Cycles from the first activation entering the array to its result leaving it.
    function automatic int unsigned lat(input int unsigned rows, input int unsigned cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/vegeta_ctrl_cnt.sv
// Up-counter with synchronous clear (dominant over enable) and a terminal compare.
module vegeta_ctrl_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             at_limit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/vegeta_array_ctrl.sv
// Tile sequencer for one VEGETA PE array: weight load/prefetch, activation streaming,
// pipeline drain and result flagging.
module vegeta_array_ctrl
    import vegeta_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ROWS = 4,
    parameter int unsigned NUM_COLS = 4,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned TILE_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              start_ready,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic [LEN_W-1:0]  cfg_act_len,
    input  logic              abort,
    input  logic              w_valid,
    output logic              w_rd_en,
    input  logic              act_valid,
    output logic              act_rd_en,
    output logic              weight_transferring,
    output logic              i_wb,
    output logic              mode,
    output logic              acc_wr_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LAT = lat(NUM_ROWS, NUM_COLS);
    localparam int unsigned MW  = LEN_W + 1;

    localparam logic [LEN_W-1:0] ROWS_L  = LEN_W'(NUM_ROWS);
    localparam logic [LEN_W-1:0] ROWS_M1 = LEN_W'(NUM_ROWS - 1);
    localparam logic [MW-1:0]    LAT_M   = MW'(LAT);
    localparam logic [MW-1:0]    LAT_M1  = MW'(LAT - 1);

    state_e             state_q;
    logic [TILE_W-1:0]  tiles_left_q;
    logic [LEN_W-1:0]   act_len_q;
    logic               i_wb_q;
    logic               done_q;
    logic               busy_q;
    logic               start_ready_q;

    logic [LEN_W-1:0]   wcnt;
    logic               wcnt_last;
    logic [LEN_W-1:0]   acnt;
    logic               acnt_last;
    logic [LEN_W-1:0]   acnt_limit;
    logic [MW-1:0]      mcnt;
    logic               mcnt_end;
    logic [MW-1:0]      mcnt_limit;

    logic in_load, in_stream, in_drain;
    logic pf_ok, w_take, a_take, mode_c, acc_c;
    logic accept, cfg_empty, load_last, stream_last, drain_end;
    logic tiles_last, wbuf_full, drain_to_stream;
    logic wcnt_clr, acnt_clr, mcnt_clr;

    always_comb begin
        in_load   = (state_q == StLoad);
        in_stream = (state_q == StStream);
        in_drain  = (state_q == StDrain);

        // Shadow-buffer prefetch only while another tile is still to come.
        pf_ok  = (tiles_left_q > TILE_W'(1)) && (wcnt < ROWS_L);
        w_take = !abort && w_valid && (in_load || ((in_stream || in_drain) && pf_ok));
        a_take = !abort && act_valid && in_stream;
        mode_c = !abort && ((in_stream && act_valid) || in_drain);
        acc_c  = mode_c && (mcnt >= LAT_M);

        accept      = !abort && start && start_ready_q;
        cfg_empty   = (cfg_tiles == '0) || (cfg_act_len == '0);
        load_last   = in_load && w_take && wcnt_last;
        stream_last = a_take && acnt_last;
        drain_end   = !abort && in_drain && mcnt_end;
        tiles_last  = (tiles_left_q == TILE_W'(1));
        // A beat landing on the final drain cycle still completes the shadow buffer.
        wbuf_full       = (wcnt == ROWS_L) || (w_take && wcnt_last);
        drain_to_stream = drain_end && !tiles_last && wbuf_full;

        acnt_limit = act_len_q - LEN_W'(1);
        mcnt_limit = {1'b0, act_len_q} + LAT_M1;

        wcnt_clr = abort || accept || load_last || drain_to_stream;
        acnt_clr = abort || accept || stream_last;
        mcnt_clr = abort || accept || drain_end;
    end

    vegeta_ctrl_cnt #(
        .WIDTH (LEN_W)
    ) u_wcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wcnt_clr),
        .en       (w_take),
        .limit    (ROWS_M1),
        .count    (wcnt),
        .at_limit (wcnt_last)
    );

    vegeta_ctrl_cnt #(
        .WIDTH (LEN_W)
    ) u_acnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (acnt_clr),
        .en       (a_take),
        .limit    (acnt_limit),
        .count    (acnt),
        .at_limit (acnt_last)
    );

    // Counts every mode cycle of the tile; its terminal value is the last drain cycle.
    vegeta_ctrl_cnt #(
        .WIDTH (MW)
    ) u_mcnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (mcnt_clr),
        .en       (mode_c),
        .limit    (mcnt_limit),
        .count    (mcnt),
        .at_limit (mcnt_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            tiles_left_q  <= '0;
            act_len_q     <= '0;
            i_wb_q        <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b0;
        end else if (abort) begin
            state_q       <= StIdle;
            tiles_left_q  <= '0;
            act_len_q     <= '0;
            i_wb_q        <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        tiles_left_q  <= cfg_tiles;
                        act_len_q     <= cfg_act_len;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        if (cfg_empty) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StLoad;
                        end
                    end else begin
                        start_ready_q <= 1'b1;
                    end
                end
                StLoad: begin
                    if (load_last) begin
                        state_q <= StStream;
                        i_wb_q  <= ~i_wb_q;
                    end
                end
                StStream: begin
                    if (stream_last) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_end) begin
                        tiles_left_q <= tiles_left_q - TILE_W'(1);
                        if (tiles_last) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else if (wbuf_full) begin
                            state_q <= StStream;
                            i_wb_q  <= ~i_wb_q;
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                StDone: begin
                    state_q       <= StIdle;
                    done_q        <= 1'b0;
                    busy_q        <= 1'b0;
                    start_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    acnt_zero_outside_stream: assert property (
        @(posedge clk) disable iff (!rst_n) (state_q != StStream) |-> (acnt == '0)
    );

    assign start_ready         = start_ready_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign i_wb                = i_wb_q;
    assign weight_transferring = w_take;
    assign w_rd_en             = w_take;
    assign act_rd_en           = a_take;
    assign mode                = mode_c;
    assign acc_wr_en           = acc_c;

endmodule

// File: tb/tb_vegeta_array_ctrl.sv
// Directed self-checking bench for vegeta_array_ctrl (NUM_ROWS = NUM_COLS = 4, LAT = 7).
module tb_vegeta_array_ctrl;

    localparam int TW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          start_ready;
    logic [TW-1:0] cfg_tiles;
    logic [LW-1:0] cfg_act_len;
    logic          abort;
    logic          w_valid;
    logic          w_rd_en;
    logic          act_valid;
    logic          act_rd_en;
    logic          weight_transferring;
    logic          i_wb;
    logic          mode;
    logic          acc_wr_en;
    logic          busy;
    logic          done;

    vegeta_array_ctrl #(
        .NUM_ROWS (4),
        .NUM_COLS (4),
        .LEN_W    (LW),
        .TILE_W   (TW)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .start_ready         (start_ready),
        .cfg_tiles           (cfg_tiles),
        .cfg_act_len         (cfg_act_len),
        .abort               (abort),
        .w_valid             (w_valid),
        .w_rd_en             (w_rd_en),
        .act_valid           (act_valid),
        .act_rd_en           (act_rd_en),
        .weight_transferring (weight_transferring),
        .i_wb                (i_wb),
        .mode                (mode),
        .acc_wr_en           (acc_wr_en),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-job observations; cycle 0 is the cycle in which start is presented.
    int   r_wt, r_last_wt, r_wt_novalid, r_wrd_bad;
    int   r_mode, r_first_mode, r_last_mode, r_gap;
    int   r_acc, r_first_acc, r_last_acc, r_act_rd;
    int   r_toggles, r_done_cycle, r_done_cnt;
    logic prev_wb;

    task automatic run_job(input int tiles, input int len, input int w_pat, input int lo_from,
                           input int lo_to, input int abort_at, input int restart_at,
                           input int max_c);
        @(posedge clk);
        #1;
        cfg_tiles   = TW'(tiles);
        cfg_act_len = LW'(len);
        start       = 1'b1;
        abort       = 1'b0;
        w_valid     = 1'b1;
        act_valid   = 1'b1;
        r_wt = 0; r_last_wt = -1; r_wt_novalid = 0; r_wrd_bad = 0;
        r_mode = 0; r_first_mode = -1; r_last_mode = -1; r_gap = 0;
        r_acc = 0; r_first_acc = -1; r_last_acc = -1; r_act_rd = 0;
        r_toggles = 0; r_done_cycle = -1; r_done_cnt = 0;
        prev_wb = i_wb;
        @(negedge clk);
        for (int c = 1; c <= max_c; c++) begin
            @(posedge clk);
            #1;
            start     = (c == restart_at);
            abort     = (c == abort_at);
            w_valid   = (w_pat == 0) ? 1'b1 : c[0];
            act_valid = !(c >= lo_from && c <= lo_to);
            @(negedge clk);
            if (weight_transferring) begin
                r_wt++;
                r_last_wt = c;
                if (!w_valid) r_wt_novalid++;
            end
            if (w_rd_en !== weight_transferring) r_wrd_bad++;
            if (mode) begin
                r_mode++;
                if (r_first_mode < 0) r_first_mode = c;
                r_last_mode = c;
            end else if (busy && !done && r_first_mode >= 0) begin
                r_gap++;
            end
            if (act_rd_en) r_act_rd++;
            if (acc_wr_en) begin
                r_acc++;
                if (r_first_acc < 0) r_first_acc = c;
                r_last_acc = c;
            end
            if (i_wb !== prev_wb) r_toggles++;
            prev_wb = i_wb;
            if (done) begin
                r_done_cnt++;
                if (r_done_cycle < 0) r_done_cycle = c;
            end
            if (abort_at > 0 && c == abort_at + 1) break;
            if (r_done_cycle >= 0 && c == r_done_cycle + 1) break;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; w_valid = 1'b1; act_valid = 1'b1;
        cfg_tiles = '0; cfg_act_len = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({start_ready, busy, done, i_wb} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_regs: got %b required 0000", {start_ready, busy, done, i_wb});
        end
        checks++;
        if ({weight_transferring, w_rd_en, mode, act_rd_en, acc_wr_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 00000",
                     {weight_transferring, w_rd_en, mode, act_rd_en, acc_wr_en});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({start_ready, busy, mode, weight_transferring} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b required 1000",
                     {start_ready, busy, mode, weight_transferring});
        end
    endtask

    task automatic test_single_tile();
        run_job(1, 3, 0, 0, 0, 0, 0, 40);
        checks++;
        if (r_wt !== 4 || r_last_wt !== 4 || r_wrd_bad !== 0) begin
            errors++;
            $display("FAIL single_wt: got cnt=%0d last=%0d rdbad=%0d required 4 4 0",
                     r_wt, r_last_wt, r_wrd_bad);
        end
        checks++;
        if (r_mode !== 10 || r_first_mode !== 5 || r_last_mode !== 14) begin
            errors++;
            $display("FAIL single_mode: got cnt=%0d first=%0d last=%0d required 10 5 14",
                     r_mode, r_first_mode, r_last_mode);
        end
        checks++;
        if (r_acc !== 3 || r_first_acc !== 12 || r_last_acc !== 14) begin
            errors++;
            $display("FAIL single_acc: got cnt=%0d first=%0d last=%0d required 3 12 14",
                     r_acc, r_first_acc, r_last_acc);
        end
        checks++;
        if (r_done_cycle !== 15 || r_done_cnt !== 1) begin
            errors++;
            $display("FAIL single_done: got cycle=%0d cnt=%0d required 15 1",
                     r_done_cycle, r_done_cnt);
        end
        checks++;
        if (r_toggles !== 1 || i_wb !== 1'b1 || start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_end: got tog=%0d i_wb=%b rdy=%b busy=%b required 1 1 1 0",
                     r_toggles, i_wb, start_ready, busy);
        end
    endtask

    task automatic test_back_to_back_tiles();
        // Extra start at cycle 10 must be ignored while busy.
        run_job(3, 8, 0, 0, 0, 0, 10, 80);
        checks++;
        if (r_wt !== 12 || r_mode !== 45 || r_act_rd !== 24) begin
            errors++;
            $display("FAIL multi_counts: got wt=%0d mode=%0d act=%0d required 12 45 24",
                     r_wt, r_mode, r_act_rd);
        end
        checks++;
        if (r_acc !== 24 || r_last_acc !== 49) begin
            errors++;
            $display("FAIL multi_acc: got cnt=%0d last=%0d required 24 49", r_acc, r_last_acc);
        end
        checks++;
        if (r_gap !== 0 || r_first_mode !== 5) begin
            errors++;
            $display("FAIL multi_no_reload: got gap=%0d first=%0d required 0 5",
                     r_gap, r_first_mode);
        end
        checks++;
        if (r_done_cycle !== 50 || r_done_cnt !== 1 || r_toggles !== 3 || i_wb !== 1'b0) begin
            errors++;
            $display("FAIL multi_done: got cyc=%0d cnt=%0d tog=%0d i_wb=%b required 50 1 3 0",
                     r_done_cycle, r_done_cnt, r_toggles, i_wb);
        end
    endtask

    task automatic test_w_valid_stall();
        run_job(1, 2, 1, 0, 0, 0, 0, 40);
        checks++;
        if (r_wt !== 4 || r_last_wt !== 7 || r_wt_novalid !== 0) begin
            errors++;
            $display("FAIL wstall_wt: got cnt=%0d last=%0d novalid=%0d required 4 7 0",
                     r_wt, r_last_wt, r_wt_novalid);
        end
        checks++;
        if (r_first_mode !== 8 || r_mode !== 9 || r_acc !== 2 || r_done_cycle !== 17) begin
            errors++;
            $display("FAIL wstall_flow: got first=%0d mode=%0d acc=%0d done=%0d req 8 9 2 17",
                     r_first_mode, r_mode, r_acc, r_done_cycle);
        end
    endtask

    task automatic test_act_bubble();
        run_job(1, 4, 0, 6, 7, 0, 0, 40);
        checks++;
        if (r_mode !== 11 || r_act_rd !== 4) begin
            errors++;
            $display("FAIL bubble_mode: got mode=%0d act=%0d required 11 4", r_mode, r_act_rd);
        end
        checks++;
        if (r_acc !== 4 || r_last_acc !== 17 || r_done_cycle !== 18) begin
            errors++;
            $display("FAIL bubble_acc: got acc=%0d last=%0d done=%0d required 4 17 18",
                     r_acc, r_last_acc, r_done_cycle);
        end
    endtask

    task automatic test_zero_cfg();
        run_job(0, 5, 0, 0, 0, 0, 0, 10);
        checks++;
        if (r_done_cycle !== 1 || r_done_cnt !== 1 || r_wt !== 0 || r_mode !== 0) begin
            errors++;
            $display("FAIL zero_tiles: got done=%0d cnt=%0d wt=%0d mode=%0d required 1 1 0 0",
                     r_done_cycle, r_done_cnt, r_wt, r_mode);
        end
        run_job(2, 0, 0, 0, 0, 0, 0, 10);
        checks++;
        if (r_done_cycle !== 1 || r_wt !== 0 || r_mode !== 0 || r_toggles !== 0) begin
            errors++;
            $display("FAIL zero_len: got done=%0d wt=%0d mode=%0d tog=%0d required 1 0 0 0",
                     r_done_cycle, r_wt, r_mode, r_toggles);
        end
    endtask

    task automatic test_abort();
        // Tile 2 drains on cycles 28..34; abort lands on cycle 30.
        run_job(3, 8, 0, 0, 0, 30, 0, 40);
        checks++;
        if (r_mode !== 25 || r_acc !== 11 || r_done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_counts: got mode=%0d acc=%0d done=%0d required 25 11 0",
                     r_mode, r_acc, r_done_cnt);
        end
        checks++;
        if ({busy, i_wb, start_ready, mode, weight_transferring, act_rd_en, acc_wr_en}
            !== 7'b0010000) begin
            errors++;
            $display("FAIL abort_idle: got %b required 0010000",
                     {busy, i_wb, start_ready, mode, weight_transferring, act_rd_en, acc_wr_en});
        end
        run_job(1, 3, 0, 0, 0, 0, 0, 40);
        checks++;
        if (r_wt !== 4 || r_acc !== 3 || r_done_cycle !== 15 || i_wb !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: got wt=%0d acc=%0d done=%0d i_wb=%b required 4 3 15 1",
                     r_wt, r_acc, r_done_cycle, i_wb);
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_back_to_back_tiles();
        test_w_valid_stall();
        test_act_bubble();
        test_zero_cfg();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
